// File: rtl/mriscv_pkg.sv
// Shared definitions for the mriscv core: sequencer state encoding, trap causes
// and the base opcodes the decoder classifies into its flag outputs.
package mriscv_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_t;

    localparam logic [1:0] TRAP_NONE     = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
    localparam logic [1:0] TRAP_MISALIGN = 2'd2;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'd3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts unacknowledged memory-request cycles; expire fires on the request
// cycle that would make the wait reach LIMIT without an acknowledge.
module mem_timeout_ctr #(
    parameter int TO_W  = 5,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] LAST = TO_W'(LIMIT - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM of the mriscv core: owns the PC, the shared memory
// port handshake and the register-file write strobe; halts in TRAP on faults.
//
// Memory handshake: mem_req stays high with mem_addr/mem_we stable until a cycle
// in which mem_ready=1 is sampled; mem_req drops in the following cycle.
// mem_ready is ignored whenever mem_req=0.
module core_sequencer
    import mriscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          TO_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_alu,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    input  logic [31:0] ls_addr,
    output logic [31:0] pc,
    output logic        instr_we,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_unused_never,
    output logic [31:0] mem_addr,
    output logic        rf_we,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [2:0]  dbg_state
);

    state_t      state, state_next;
    logic [31:0] tgt_q, ls_q;
    logic        taken_q;
    logic        mem_busy, mem_we_c, to_expire;
    logic [1:0]  cause_next;

    mem_timeout_ctr #(.TO_W(TO_W), .LIMIT(MEM_TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!mem_busy),
        .en     (mem_req && !mem_ready),
        .expire (to_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            tgt_q      <= '0;
            ls_q       <= '0;
            taken_q    <= 1'b0;
            trap_cause <= TRAP_NONE;
        end else begin
            state <= state_next;
            if (state == ST_EXECUTE) begin
                tgt_q   <= target_addr;
                ls_q    <= ls_addr;
                taken_q <= branch_taken;
            end
            if (state == ST_WB) begin
                pc <= (is_jump || (is_branch && taken_q)) ? tgt_q : pc + 32'd4;
            end
            if (state != ST_TRAP && state_next == ST_TRAP) begin
                trap_cause <= cause_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        cause_next = TRAP_NONE;
        decode_en  = 1'b0;
        exec_en    = 1'b0;
        rf_we      = 1'b0;
        mem_busy   = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr   = 32'h0;
        case (state)
            ST_FETCH: begin
                mem_busy = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (to_expire) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                decode_en  = 1'b1;
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                exec_en = 1'b1;
                if (!(is_load || is_store || is_branch || is_jump || is_alu)) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_ILLEGAL;
                end else if ((is_jump || (is_branch && branch_taken)) &&
                             !word_aligned(target_addr)) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_MISALIGN;
                end else if (is_load || is_store) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WB;
                end
            end
            ST_MEM: begin
                mem_busy = 1'b1;
                mem_addr = ls_q;
                mem_we_c = is_store;
                if (mem_ready) begin
                    state_next = ST_WB;
                end else if (to_expire) begin
                    state_next = ST_TRAP;
                    cause_next = TRAP_TIMEOUT;
                end
            end
            ST_WB: begin
                rf_we      = is_load || is_alu || is_jump;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Gating with reset makes the request fall the instant reset asserts.
    assign mem_req               = mem_busy && !reset;
    assign mem_we                = mem_we_c && !reset;
    assign instr_we              = mem_req && mem_ready && (state == ST_FETCH);
    assign halted                = (state == ST_TRAP);
    assign dbg_state             = state;
    assign mem_addr_unused_never = 1'b0;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a per-cycle vector table for the normal
// instruction mix, then hand-written sequences for traps, timeouts and reset.
module tb_core_sequencer;
    import mriscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ready, is_load, is_store, is_branch, is_jump, is_alu, branch_taken;
    logic [31:0] target_addr, ls_addr;
    logic [31:0] pc, mem_addr;
    logic        instr_we, decode_en, exec_en, mem_req, mem_we, rf_we, halted, spare;
    logic [1:0]  trap_cause;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] F_ALU = 5'b00001, F_JMP = 5'b00010, F_BR = 5'b00100,
                           F_STR = 5'b01000, F_LD = 5'b10000, F_NONE = 5'b00000;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3,
                           S_W = 3'd4, S_T = 3'd5;

    core_sequencer #(.RESET_PC(32'h0), .MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .is_jump(is_jump), .is_alu(is_alu), .branch_taken(branch_taken),
        .target_addr(target_addr), .ls_addr(ls_addr),
        .pc(pc), .instr_we(instr_we), .decode_en(decode_en), .exec_en(exec_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_unused_never(spare),
        .mem_addr(mem_addr), .rf_we(rf_we), .halted(halted),
        .trap_cause(trap_cause), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [4:0]  fl;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] ls;
        logic [2:0]  st;
        logic [31:0] pc;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic        iwe;
        logic        rwe;
    } vec_t;

    vec_t tbl[41];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [4:0] fl, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] ls);
        mem_ready = rdy;
        {is_load, is_store, is_branch, is_jump, is_alu} = fl;
        branch_taken = tk;
        target_addr  = tgt;
        ls_addr      = ls;
    endtask

    task automatic cyc(input logic rdy, input logic [4:0] fl, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] ls);
        drive(rdy, fl, tk, tgt, ls);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, F_NONE, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cause", trap_cause, TRAP_NONE);
        chk("rst_pc", pc, 32'h0);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_instr_we", instr_we, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic sv(input int i, input logic rdy, input logic [4:0] fl, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] ls, input logic [2:0] st,
                      input logic [31:0] epc, input logic req, input logic we,
                      input logic [31:0] addr, input logic iwe, input logic rwe);
        tbl[i] = '{rdy, fl, tk, tgt, ls, st, epc, req, we, addr, iwe, rwe};
    endtask

    initial begin
        // ALU x2, load with 3 wait states, store with 1, taken/not-taken branch, jump, fetch waits
        sv( 0, 1, F_ALU, 0, 0, 0, S_F, 32'h0, 1, 0, 32'h0, 1, 0);
        sv( 1, 1, F_ALU, 0, 0, 0, S_D, 32'h0, 0, 0, 32'h0, 0, 0);
        sv( 2, 1, F_ALU, 0, 0, 0, S_E, 32'h0, 0, 0, 32'h0, 0, 0);
        sv( 3, 1, F_ALU, 0, 0, 0, S_W, 32'h0, 0, 0, 32'h0, 0, 1);
        sv( 4, 1, F_ALU, 0, 0, 0, S_F, 32'h4, 1, 0, 32'h4, 1, 0);
        sv( 5, 1, F_ALU, 0, 0, 0, S_D, 32'h4, 0, 0, 32'h0, 0, 0);
        sv( 6, 1, F_ALU, 0, 0, 0, S_E, 32'h4, 0, 0, 32'h0, 0, 0);
        sv( 7, 1, F_ALU, 0, 0, 0, S_W, 32'h4, 0, 0, 32'h0, 0, 1);
        sv( 8, 1, F_LD, 0, 0, 32'h100, S_F, 32'h8, 1, 0, 32'h8, 1, 0);
        sv( 9, 1, F_LD, 0, 0, 32'h100, S_D, 32'h8, 0, 0, 32'h0, 0, 0);
        sv(10, 0, F_LD, 0, 0, 32'h100, S_E, 32'h8, 0, 0, 32'h0, 0, 0);
        sv(11, 0, F_LD, 0, 0, 32'h999, S_M, 32'h8, 1, 0, 32'h100, 0, 0);
        sv(12, 0, F_LD, 0, 0, 32'h999, S_M, 32'h8, 1, 0, 32'h100, 0, 0);
        sv(13, 0, F_LD, 0, 0, 32'h999, S_M, 32'h8, 1, 0, 32'h100, 0, 0);
        sv(14, 1, F_LD, 0, 0, 32'h999, S_M, 32'h8, 1, 0, 32'h100, 0, 0);
        sv(15, 0, F_LD, 0, 0, 32'h999, S_W, 32'h8, 0, 0, 32'h0, 0, 1);
        sv(16, 1, F_STR, 0, 0, 32'h200, S_F, 32'hC, 1, 0, 32'hC, 1, 0);
        sv(17, 1, F_STR, 0, 0, 32'h200, S_D, 32'hC, 0, 0, 32'h0, 0, 0);
        sv(18, 0, F_STR, 0, 0, 32'h200, S_E, 32'hC, 0, 0, 32'h0, 0, 0);
        sv(19, 0, F_STR, 0, 0, 32'h200, S_M, 32'hC, 1, 1, 32'h200, 0, 0);
        sv(20, 1, F_STR, 0, 0, 32'h200, S_M, 32'hC, 1, 1, 32'h200, 0, 0);
        sv(21, 0, F_STR, 0, 0, 32'h200, S_W, 32'hC, 0, 0, 32'h0, 0, 0);
        sv(22, 1, F_BR, 1, 32'h40, 0, S_F, 32'h10, 1, 0, 32'h10, 1, 0);
        sv(23, 1, F_BR, 1, 32'h40, 0, S_D, 32'h10, 0, 0, 32'h0, 0, 0);
        sv(24, 1, F_BR, 1, 32'h40, 0, S_E, 32'h10, 0, 0, 32'h0, 0, 0);
        sv(25, 1, F_BR, 0, 32'h99, 0, S_W, 32'h10, 0, 0, 32'h0, 0, 0);
        sv(26, 1, F_BR, 0, 32'h82, 0, S_F, 32'h40, 1, 0, 32'h40, 1, 0);
        sv(27, 1, F_BR, 0, 32'h82, 0, S_D, 32'h40, 0, 0, 32'h0, 0, 0);
        sv(28, 1, F_BR, 0, 32'h82, 0, S_E, 32'h40, 0, 0, 32'h0, 0, 0);
        sv(29, 1, F_BR, 0, 32'h82, 0, S_W, 32'h40, 0, 0, 32'h0, 0, 0);
        sv(30, 1, F_JMP, 0, 32'h400, 0, S_F, 32'h44, 1, 0, 32'h44, 1, 0);
        sv(31, 1, F_JMP, 0, 32'h400, 0, S_D, 32'h44, 0, 0, 32'h0, 0, 0);
        sv(32, 1, F_JMP, 0, 32'h400, 0, S_E, 32'h44, 0, 0, 32'h0, 0, 0);
        sv(33, 1, F_JMP, 0, 32'h400, 0, S_W, 32'h44, 0, 0, 32'h0, 0, 1);
        sv(34, 0, F_ALU, 0, 0, 0, S_F, 32'h400, 1, 0, 32'h400, 0, 0);
        sv(35, 0, F_ALU, 0, 0, 0, S_F, 32'h400, 1, 0, 32'h400, 0, 0);
        sv(36, 1, F_ALU, 0, 0, 0, S_F, 32'h400, 1, 0, 32'h400, 1, 0);
        sv(37, 1, F_ALU, 0, 0, 0, S_D, 32'h400, 0, 0, 32'h0, 0, 0);
        sv(38, 1, F_ALU, 0, 0, 0, S_E, 32'h400, 0, 0, 32'h0, 0, 0);
        sv(39, 1, F_ALU, 0, 0, 0, S_W, 32'h400, 0, 0, 32'h0, 0, 1);
        sv(40, 0, F_ALU, 0, 0, 0, S_F, 32'h404, 1, 0, 32'h404, 0, 0);

        do_reset();
        for (int i = 0; i < 41; i++) begin
            drive(tbl[i].rdy, tbl[i].fl, tbl[i].tk, tbl[i].tgt, tbl[i].ls);
            #1;
            chk($sformatf("v%0d_state", i), dbg_state, tbl[i].st);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("v%0d_mem_req", i), mem_req, tbl[i].req);
            chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].we);
            if (tbl[i].req) chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("v%0d_instr_we", i), instr_we, tbl[i].iwe);
            chk($sformatf("v%0d_rf_we", i), rf_we, tbl[i].rwe);
            chk($sformatf("v%0d_decode_en", i), decode_en, tbl[i].st == S_D);
            chk($sformatf("v%0d_exec_en", i), exec_en, tbl[i].st == S_E);
            chk($sformatf("v%0d_halted", i), halted, 1'b0);
            @(posedge clk);
            #1;
        end

        // Misaligned jump target: trap with cause 2, pc frozen, no requests
        do_reset();
        cyc(1, F_JMP, 0, 32'h42, 0);
        cyc(1, F_JMP, 0, 32'h42, 0);
        cyc(1, F_JMP, 0, 32'h42, 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, F_JMP, 0, 32'h42, 0);
            #1;
            chk("misalign_halted", halted, 1'b1);
            chk("misalign_cause", trap_cause, TRAP_MISALIGN);
            chk("misalign_pc", pc, 32'h0);
            chk("misalign_mem_req", mem_req, 1'b0);
            @(posedge clk);
            #1;
        end

        // No decoder flags: illegal instruction
        do_reset();
        repeat (3) cyc(1, F_NONE, 0, 0, 0);
        chk("illegal_halted", halted, 1'b1);
        chk("illegal_cause", trap_cause, TRAP_ILLEGAL);
        chk("illegal_state", dbg_state, S_T);

        // Fetch never acknowledged: trap on the 16th waiting cycle
        do_reset();
        repeat (15) cyc(0, F_ALU, 0, 0, 0);
        drive(0, F_ALU, 0, 0, 0);
        #1;
        chk("to15_state", dbg_state, S_F);
        chk("to15_mem_req", mem_req, 1'b1);
        @(posedge clk);
        #1;
        chk("to16_halted", halted, 1'b1);
        chk("to16_cause", trap_cause, TRAP_TIMEOUT);
        chk("to16_mem_req", mem_req, 1'b0);

        // Acknowledge on the 16th cycle wins over the limit
        do_reset();
        repeat (15) cyc(0, F_ALU, 0, 0, 0);
        drive(1, F_ALU, 0, 0, 0);
        #1;
        chk("late_ack_instr_we", instr_we, 1'b1);
        @(posedge clk);
        #1;
        chk("late_ack_state", dbg_state, S_D);
        chk("late_ack_halted", halted, 1'b0);
        repeat (3) cyc(1, F_ALU, 0, 0, 0);
        chk("late_ack_next_pc", pc, 32'h4);

        // Counter restarts on MEM entry: 10 fetch waits, then a MEM timeout
        do_reset();
        repeat (10) cyc(0, F_LD, 0, 0, 32'h104);
        repeat (3) cyc(1, F_LD, 0, 0, 32'h104);
        repeat (15) cyc(0, F_LD, 0, 0, 32'h104);
        drive(0, F_LD, 0, 0, 32'h104);
        #1;
        chk("memto15_state", dbg_state, S_M);
        chk("memto15_addr", mem_addr, 32'h104);
        chk("memto15_halted", halted, 1'b0);
        @(posedge clk);
        #1;
        chk("memto_halted", halted, 1'b1);
        chk("memto_cause", trap_cause, TRAP_TIMEOUT);
        chk("memto_pc", pc, 32'h0);

        // Reset asserted while MEM waits: request drops immediately
        do_reset();
        repeat (3) cyc(1, F_LD, 0, 0, 32'h108);
        repeat (2) cyc(0, F_LD, 0, 0, 32'h108);
        drive(0, F_LD, 0, 0, 32'h108);
        #1;
        chk("rstmem_req_before", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        chk("rstmem_req_async", mem_req, 1'b0);
        chk("rstmem_state", dbg_state, S_F);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rstmem_req_after", mem_req, 1'b1);
        chk("rstmem_addr_after", mem_addr, 32'h0);
        chk("rstmem_halted", halted, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the mriscv core. It sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU and register file. It owns the PC, the single shared memory port handshake, and the register-file write enable. It halts into a trap state on illegal opcode, misaligned control-flow target or memory timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 16, max cycles mem_req may stay unacknowledged before trap (≥1)
TO_W, 5, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
mem_ready  in  1  memory acknowledge; valid only while mem_req=1
is_load  in  1  decoder flag (registered, valid from EXECUTE)
is_store  in  1  decoder flag
is_branch  in  1  decoder flag
is_jump  in  1  decoder flag
is_alu  in  1  decoder flag
branch_taken  in  1  comparator result, valid in EXECUTE
target_addr  in  32  branch/jump destination, valid in EXECUTE
ls_addr  in  32  load/store effective address, valid in EXECUTE
pc  out  32  current instruction address
instr_we  out  1  one-cycle pulse: latch fetched instruction word
decode_en  out  1  high in DECODE
exec_en  out  1  high in EXECUTE
mem_req  out  1  memory request
mem_we  out  1  write strobe, qualified by mem_req
mem_addr  out  32  memory address, qualified by mem_req
rf_we  out  1  register-file write pulse
halted  out  1  high in TRAP
trap_cause  out  2  0 none, 1 illegal, 2 misaligned target, 3 mem timeout

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Reset state: FETCH.
- Reset (asynchronous, immediate, also mid-transaction): pc=RESET_PC, all pulses/strobes 0, mem_req=0, halted=0, trap_cause=0, timeout counter=0. The first fetch request is issued in the first cycle after reset deasserts.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. If mem_ready=1 in this cycle, instr_we pulses for the same cycle and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: decode_en=1 for one cycle. Next state is EXECUTE.
- EXECUTE: exec_en=1. The sequencer latches target_addr, ls_addr and branch_taken into internal registers.
  - If none of is_load/is_store/is_branch/is_jump/is_alu is set, go to TRAP with cause 1.
  - If (is_jump or (is_branch and branch_taken)) and target_addr[1:0]≠0, go to TRAP with cause 2.
  - Else if is_load or is_store, go to MEM.
  - Else go to WB.
- MEM: mem_req=1, mem_addr=latched ls_addr, mem_we=is_store. On mem_ready=1, go to WB.
- WB:
  - rf_we=1 for one cycle if is_load, is_alu or is_jump.
  - pc ← latched target if is_jump or a taken branch, else pc+4. Wrap-around modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - Next state is FETCH.
- Handshake rules: while mem_req=1, mem_addr and mem_we are stable. mem_req drops in the cycle after mem_ready is sampled. mem_ready while mem_req=0 is ignored.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT, go to TRAP with cause 3.
  - If mem_ready arrives in the same cycle the limit is hit, mem_ready wins.
- TRAP: halted=1. trap_cause holds its value. mem_req=0. pc is frozen at the faulting instruction. Leaves only on reset.
- Latency with zero-wait memory: ALU/branch/jump takes 4 cycles per instruction; load/store takes 5.

Decomposition:
- Package mriscv_pkg holds:
  - state encoding typedef (3-bit)
  - trap cause constants TRAP_NONE/ILLEGAL/MISALIGN/TIMEOUT
  - opcode constants shared with the decoder
- One sub-module, mem_timeout_ctr: a TO_W-bit counter with clear/enable inputs and an expire output, reused for both memory phases.

Test Plan:
- Reset, then mem_ready tied 1 with ALU instr (is_alu=1) → pc 0→4→8. The sequence FETCH, DECODE, EXECUTE, WB repeats every 4 cycles, with one rf_we pulse per instruction.
- Load with ls_addr=32'h100 and mem_ready delayed 3 cycles in MEM → mem_addr=32'h100 and mem_we=0 held stable 4 cycles, then rf_we pulses and pc=+4. A store variant has mem_we=1 and no rf_we.
- Taken branch with target_addr=32'h40 → next fetch mem_addr=32'h40. Not-taken branch → pc+4. Jump → rf_we=1 and pc=target.
- Jump with target_addr=32'h42 → halted=1 and trap_cause=2. pc holds the jump address and mem_req stays 0 indefinitely.
- No decoder flags set → TRAP with cause 1. mem_ready held 0 for 16 cycles in FETCH → TRAP with cause 3. mem_ready arriving on cycle 16 → no trap.
- Assert reset during a MEM wait → mem_req falls in the same cycle (async). After release, fetch starts at RESET_PC with halted=0.
